// File: rtl/div_seq_pkg.sv
// Shared types for the div_seq iterative divider: ALU select codes, RV32M divide
// opcodes, FSM state encoding and the debug observation struct.
package div_seq_pkg;

    localparam int ALUSEL_W = 4;
    typedef logic [ALUSEL_W-1:0] alu_sel_t;
    localparam alu_sel_t ALUSEL_ADD = 4'd0;
    localparam alu_sel_t ALUSEL_SUB = 4'd1;

    typedef enum logic [1:0] {
        DIVOP_DIV  = 2'b00,
        DIVOP_DIVU = 2'b01,
        DIVOP_REM  = 2'b10,
        DIVOP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS_A = 3'd1,
        ST_ABS_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

    typedef struct packed {
        div_state_e state;
        logic [4:0] cnt;
        logic       step_ok;
    } div_dbg_t;

    // Bit 0 of the opcode selects unsigned, bit 1 selects remainder.
    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result and shared-ALU signal bundle for div_seq. The master side
// requests divides and also models the shared ALU result path.
interface div_seq_if #(parameter int WIDTH = 32);
    import div_seq_pkg::*;

    // start_i is a level request sampled only while busy_o is low; done_o is a
    // single-cycle pulse and result_o stays stable until the next done_o.
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             alu_req_o;
    logic [WIDTH-1:0] alu_a_o;
    logic [WIDTH-1:0] alu_b_o;
    alu_sel_t         alu_sel_o;
    logic [WIDTH-1:0] alu_res_i;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i, alu_res_i,
        input  busy_o, done_o, result_o, alu_req_o, alu_a_o, alu_b_o, alu_sel_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i, alu_res_i,
        output busy_o, done_o, result_o, alu_req_o, alu_a_o, alu_b_o, alu_sel_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One restoring-division step: shift, local unsigned compare, and selection
// between the borrowed ALU difference and the shifted partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] abs_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] s_low,
    output logic             ok,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] s;

    // A set s[WIDTH] means s exceeds any divisor; the wrapped ALU difference is still exact.
    always_comb begin
        s        = {rem, quo[WIDTH-1]};
        s_low    = s[WIDTH-1:0];
        ok       = s[WIDTH] | (s_low >= abs_b);
        rem_next = ok ? alu_res : s_low;
        quo_next = {quo[WIDTH-2:0], ok};
    end

endmodule

// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer that borrows the EX-stage ALU.
// Optional last-result reuse for DIV/REM pairs is enabled by defining DIV_REUSE_EN.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus,
    output div_dbg_t   dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] s_low;
    logic             step_ok;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    logic             req_signed;
    logic             req_rem;
    logic             req_overflow;
    logic             neg_a;
    logic             neg_b;
    logic             fix_neg;
    logic [WIDTH-1:0] fix_val;

    logic             alu_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    alu_sel_t         alu_sel;

`ifdef DIV_REUSE_EN
    logic             last_valid;
    logic             last_signed;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [WIDTH-1:0] last_quo;
    logic [WIDTH-1:0] last_rem;
    logic             reuse_hit;
    logic             reuse_neg;
    logic [WIDTH-1:0] reuse_mag;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .abs_b    (abs_b),
        .alu_res  (bus.alu_res_i),
        .s_low    (s_low),
        .ok       (step_ok),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        req_signed   = op_signed(bus.op_i);
        req_rem      = op_rem(bus.op_i);
        req_overflow = req_signed && (bus.dividend_i == INT_MIN) && (bus.divisor_i == '1);
        neg_a        = op_signed(op_q) & a_q[WIDTH-1];
        neg_b        = op_signed(op_q) & b_q[WIDTH-1];
        fix_val      = op_rem(op_q) ? rem_q : quo_q;
        // The remainder takes the dividend's sign, the quotient the XOR of both signs.
        fix_neg      = op_rem(op_q) ? neg_a : (neg_a ^ neg_b);
    end

`ifdef DIV_REUSE_EN
    always_comb begin
        reuse_hit = last_valid && (bus.dividend_i == last_a) && (bus.divisor_i == last_b)
                    && (req_signed == last_signed);
        reuse_neg = req_signed && (req_rem ? bus.dividend_i[WIDTH-1]
                                           : (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]));
        reuse_mag = req_rem ? last_rem : last_quo;
    end
`endif

    // ALU operands are decoded from registered state only, so there is no
    // input-to-output path apart from alu_res_i feeding back into state.
    always_comb begin
        alu_req = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALUSEL_ADD;
        case (state)
            ST_ABS_A: begin
                alu_req = 1'b1;
                if (neg_a) begin
                    alu_b   = a_q;
                    alu_sel = ALUSEL_SUB;
                end else begin
                    alu_a   = a_q;
                end
            end
            ST_ABS_B: begin
                alu_req = 1'b1;
                if (neg_b) begin
                    alu_b   = b_q;
                    alu_sel = ALUSEL_SUB;
                end else begin
                    alu_a   = b_q;
                end
            end
            ST_ITER: begin
                alu_req = 1'b1;
                alu_a   = s_low;
                alu_b   = abs_b;
                alu_sel = ALUSEL_SUB;
            end
            ST_FIX: begin
                alu_req = 1'b1;
                if (fix_neg) begin
                    alu_b   = fix_val;
                    alu_sel = ALUSEL_SUB;
                end else begin
                    alu_a   = fix_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            abs_b    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt      <= '0;
            result_q <= '0;
`ifdef DIV_REUSE_EN
            last_valid  <= 1'b0;
            last_signed <= 1'b0;
            last_a      <= '0;
            last_b      <= '0;
            last_quo    <= '0;
            last_rem    <= '0;
`endif
        end else if (bus.flush_i) begin
            state <= ST_IDLE;
`ifdef DIV_REUSE_EN
            last_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        op_q <= bus.op_i;
                        a_q  <= bus.dividend_i;
                        b_q  <= bus.divisor_i;
                        if (bus.divisor_i == '0) begin
                            result_q <= req_rem ? bus.dividend_i : '1;
                            state    <= ST_DONE;
                        end else if (req_overflow) begin
                            result_q <= req_rem ? '0 : INT_MIN;
                            state    <= ST_DONE;
                        end
`ifdef DIV_REUSE_EN
                        else if (reuse_hit) begin
                            result_q <= reuse_neg ? (~reuse_mag + 1'b1) : reuse_mag;
                            state    <= ST_DONE;
                        end
`endif
                        else begin
                            state <= ST_ABS_A;
                        end
                    end
                end
                ST_ABS_A: begin
                    quo_q <= bus.alu_res_i;
                    state <= ST_ABS_B;
                end
                ST_ABS_B: begin
                    abs_b <= bus.alu_res_i;
                    rem_q <= '0;
                    cnt   <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_q <= bus.alu_res_i;
                    state    <= ST_DONE;
`ifdef DIV_REUSE_EN
                    last_valid  <= 1'b1;
                    last_signed <= op_signed(op_q);
                    last_a      <= a_q;
                    last_b      <= b_q;
                    last_quo    <= quo_q;
                    last_rem    <= rem_q;
`endif
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o    = (state != ST_IDLE);
    assign bus.done_o    = (state == ST_DONE);
    assign bus.result_o  = result_q;
    assign bus.alu_req_o = alu_req;
    assign bus.alu_a_o   = alu_a;
    assign bus.alu_b_o   = alu_b;
    assign bus.alu_sel_o = alu_sel;

    assign dbg.state   = state;
    assign dbg.cnt     = cnt;
    assign dbg.step_ok = step_ok;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a behavioural shared ALU plus hand-computed
// quotients, remainders, latencies and ALU-claim counts.
module tb_div_seq;
    import div_seq_pkg::*;

`ifdef DIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif
    localparam int HIT_LAT = REUSE ? 1 : 36;
    localparam int HIT_REQ = REUSE ? 0 : 35;

    logic     clk;
    logic     rst;
    div_dbg_t dbg;
    int       checks;
    int       errors;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dbg (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared execute-stage ALU.
    always_comb begin
        if (bus.alu_sel_o == ALUSEL_SUB) bus.alu_res_i = bus.alu_a_o - bus.alu_b_o;
        else                             bus.alu_res_i = bus.alu_a_o + bus.alu_b_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it until done_o, counting latency and ALU claims.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_req, input bit poke);
        int lat;
        int req_n;
        bit seen;
        lat   = 0;
        req_n = 0;
        seen  = 1'b0;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (poke && k == 5) begin
                bus.start_i    = 1'b1;
                bus.op_i       = DIVOP_DIVU;
                bus.dividend_i = 32'd9;
                bus.divisor_i  = 32'd3;
            end
            if (poke && k == 6) bus.start_i = 1'b0;
            if (bus.alu_req_o) req_n++;
            if (bus.done_o) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_alu_req_cycles"}, 32'(req_n), 32'(exp_req));
        check({tag, "_result"}, bus.result_o, exp_res);
    endtask

    initial begin
        bit seen_done;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.op_i       = DIVOP_DIV;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.flush_i    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_alu_req", 32'(bus.alu_req_o), 32'd0);
        check("rst_alu_a", bus.alu_a_o, 32'd0);
        check("rst_alu_b", bus.alu_b_o, 32'd0);
        check("rst_alu_sel", 32'(bus.alu_sel_o), 32'(ALUSEL_ADD));
        check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
        rst = 1'b0;

        run_op("div_100_7",  DIVOP_DIV,  32'd100, 32'd7, 32'd14, 36, 35, 1'b0);
        run_op("rem_100_7",  DIVOP_REM,  32'd100, 32'd7, 32'd2, HIT_LAT, HIT_REQ, 1'b0);
        run_op("divu_100_7", DIVOP_DIVU, 32'd100, 32'd7, 32'd14, 36, 35, 1'b0);
        run_op("div_m100_7", DIVOP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 36, 35, 1'b0);
        run_op("rem_m100_7", DIVOP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, HIT_LAT, HIT_REQ, 1'b0);
        run_op("divu_carry", DIVOP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 36, 35, 1'b0);
        run_op("remu_carry", DIVOP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, HIT_LAT, HIT_REQ, 1'b0);
        run_op("div_7_m2",   DIVOP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 36, 35, 1'b1);
        run_op("rem_7_m2",   DIVOP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, HIT_LAT, HIT_REQ, 1'b0);

        // Flush mid-operation: no done_o and result_o keeps the previous value.
        seen_done = 1'b0;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = DIVOP_DIV;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd10;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (bus.done_o) seen_done = 1'b1;
            if (k == 10) bus.flush_i = 1'b1;
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        check("flush_state", 32'(dbg.state), 32'(ST_IDLE));
        check("flush_no_done", 32'(seen_done | bus.done_o), 32'd0);
        check("flush_result_held", bus.result_o, 32'd1);
        run_op("div_after_flush", DIVOP_DIV, 32'd1000, 32'd10, 32'd100, 36, 35, 1'b0);

        // Flush wins over a simultaneous start.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.flush_i    = 1'b1;
        bus.dividend_i = 32'd50;
        bus.divisor_i  = 32'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_start_busy", 32'(bus.busy_o), 32'd0);

        run_op("div_1000_10", DIVOP_DIV, 32'd1000, 32'd10, 32'd100, 36, 35, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = DIVOP_DIV;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_alu_req", 32'(bus.alu_req_o), 32'd0);
        check("midrst_state", 32'(dbg.state), 32'(ST_IDLE));
        rst = 1'b0;
        run_op("rem_after_rst", DIVOP_REM, 32'd1000, 32'd10, 32'd0, 36, 35, 1'b0);

        run_op("div_by_zero",  DIVOP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op("rem_by_zero",  DIVOP_REM,  32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
        run_op("divu_by_zero", DIVOP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op("remu_by_zero", DIVOP_REMU, 32'hABCD_0123, 32'd0, 32'hABCD_0123, 1, 0, 1'b0);
        run_op("div_ovf",      DIVOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
        run_op("rem_ovf",      DIVOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
        run_op("divu_no_ovf",  DIVOP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 36, 35, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divide sequencer for RV32M DIV/DIVU/REM/REMU. It borrows the shared execute-stage ALU for every subtraction and negation, using its ALUSEL_SUB and ALUSEL_ADD operations, and holds only the shift and compare logic locally. It sits beside the ALU in EX. While it runs, the EX-stage ALU input mux selects its operands over the pipeline's, and it stalls the pipeline through busy_o.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  WIDTH  rs1 value.
- divisor_i  in  WIDTH  rs2 value.
- flush_i  in  1  abort the current operation.
- busy_o  out  1  high in every state other than IDLE.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  WIDTH  result; holds until the next done_o.
- alu_req_o  out  1  claims the shared ALU this cycle.
- alu_a_o, alu_b_o  out  WIDTH  ALU operands.
- alu_sel_o  out  `ALUSEL_BUS  ALU operation select.
- alu_res_i  in  WIDTH  combinational ALU result, same cycle.

## Operation
- States: IDLE, ABS_A, ABS_B, ITER, FIX, DONE.
- IDLE + start_i: latch op, dividend, divisor.
  - Divisor == 0 → DONE. Result: 0xFFFFFFFF for DIV/DIVU; dividend for REM/REMU.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF → DONE. Result: 0x80000000 for DIV; 0 for REM.
  - Otherwise → ABS_A.
- ABS_A: drive ALU with A = 0, B = dividend, SUB when the op is signed and dividend[31] is set. Otherwise drive A = dividend, B = 0, ADD. Latch alu_res_i as |a|. → ABS_B.
- ABS_B: same scheme for the divisor, producing |b|. Clear the iteration counter. → ITER.
- ITER, 32 cycles, restoring division:
  - Form a 33-bit shifted value s = {R, Q[31]}.
  - ok = s[32] | (s[31:0] >= |b|), using an unsigned comparator local to the block.
  - Drive ALU with A = s[31:0], B = |b|, SUB.
  - If ok, R ← alu_res_i; otherwise R ← s[31:0].
  - Q ← {Q[30:0], ok}.
  - Counter == 31 → FIX.
- FIX:
  - Negation conditions: the quotient is negated when the op is signed and the operand signs differ. The remainder is negated when the op is signed and the dividend is negative.
  - Drive ALU with A = 0, B = selected value, SUB when negation is required. Otherwise drive A = value, B = 0, ADD.
  - Latch result_o. → DONE.
- DONE: done_o = 1. → IDLE.
- alu_req_o = 1 in ABS_A, ABS_B, ITER and FIX only. When it is 0: alu_a_o = 0, alu_b_o = 0, alu_sel_o = ALUSEL_ADD.
- start_i outside IDLE is ignored.
- flush_i in any state → IDLE next cycle. No done_o; result_o is unchanged. flush_i wins over a simultaneous start_i.

## Timing
- Reset values: state IDLE; busy_o, done_o, alu_req_o = 0; result_o, alu_a_o, alu_b_o = 0; alu_sel_o = ALUSEL_ADD; all internal registers 0.
- Cycle numbering: start_i is accepted at edge N.
  - Normal path: ABS_A during N+1, ABS_B N+2, ITER N+3..N+34, FIX N+35, done_o during N+36. Fixed latency 36 cycles.
  - Zero-divisor and overflow cases: done_o during N+1.
- The earliest following start_i is accepted in the cycle after done_o.
- Reset asserted mid-operation forces the reset values at the next edge.

## Configuration
- DIV_REUSE_EN defined:
  - Keep last dividend, divisor, signedness, final quotient and final remainder, updated at FIX.
  - An IDLE start_i with identical operands and signedness (a DIV↔REM pair) → DONE directly; done_o during N+1. The ALU is not requested.
  - rst and flush_i invalidate the stored entry.
- Not defined: every request takes the full path; no extra registers.

## Structure
- DIVOP_* opcode defines go in core_param.v, alongside ALUSEL_*.
- State encoding uses module-local localparams.
- Sub-module div_step (combinational): takes R, Q, |b|, alu_res_i; produces s, ok, next R, next Q.

## Test plan
- DIV 100 / 7 → 14; REM → 2. done_o at N+36; alu_req_o high N+1..N+35.
- DIV −100 / 7 → 0xFFFFFFF2; REM −100 / 7 → 0xFFFFFFFE.
- DIVU 0xFFFFFFFF / 0x80000000 → 1; REMU → 0x7FFFFFFF. Exercises the s[32] carry.
- DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000. All with done_o at N+1.
- start_i, then flush_i at N+10 → IDLE at N+11; no done_o, result_o unchanged. A new start_i at N+11 completes normally.
- With DIV_REUSE_EN: DIV 100 / 7 followed by REM 100 / 7 → REM done_o at N+1, value 2. DIVU on the same operands → full 36 cycles.
